// File: rtl/gat_row_base_addr_gen.sv
// Row-base address generator: issues n*feat_dim requests to an external pipelined
// multiplier and streams the products, tagged with node index and last flag, through an output FIFO.
module gat_row_base_addr_gen #(
    parameter int unsigned NODE_W  = 12,
    parameter int unsigned DIM_W   = 8,
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DEPTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NODE_W-1:0] num_nodes,
    input  logic [DIM_W-1:0]  feat_dim,
    output logic              busy,
    output logic              done,
    output logic              mul_ce,
    output logic [NODE_W-1:0] mul_a,
    output logic [DIM_W-1:0]  mul_b,
    input  logic [ADDR_W-1:0] mul_p,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr,
    output logic [NODE_W-1:0] addr_node,
    output logic              addr_last
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(DEPTH + MUL_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              state_q;
    logic [NODE_W-1:0]   n_q, num_q, mula_q;
    logic [DIM_W-1:0]    feat_q;
    logic                busy_q, done_q;
    logic [MUL_LAT-1:0]  vld_q;
    logic [NODE_W-1:0]   tag_node_q [MUL_LAT];
    logic                tag_last_q [MUL_LAT];
    logic [ADDR_W-1:0]   mem_addr [DEPTH];
    logic [NODE_W-1:0]   mem_node [DEPTH];
    logic                mem_last [DEPTH];
    logic [PW-1:0]       wr_q, rd_q;
    logic [CW-1:0]       cnt_q;

    logic [SW-1:0]       inflight, used;
    logic                issue, is_last, push, pop, drained;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < MUL_LAT; i++) begin
            inflight = inflight + SW'(vld_q[i]);
        end
        used    = SW'(cnt_q) + inflight;
        // Credit counts both queued and in-flight products; a same-cycle pop earns nothing.
        issue   = (state_q == S_ISSUE) && (used < SW'(DEPTH));
        is_last = (n_q == (num_q - NODE_W'(1)));
        mul_a   = issue ? n_q : mula_q;
        push    = vld_q[MUL_LAT-1];
        pop     = (cnt_q != '0) && addr_ready;
        // Finish in the cycle the final entry is handed off so done follows immediately.
        drained = (vld_q == '0) && ((cnt_q == '0) || ((cnt_q == CW'(1)) && pop));
    end

    assign mul_ce     = 1'b1;
    assign mul_b      = feat_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign addr_valid = (cnt_q != '0);
    assign addr       = addr_valid ? mem_addr[rd_q] : '0;
    assign addr_node  = addr_valid ? mem_node[rd_q] : '0;
    assign addr_last  = addr_valid & mem_last[rd_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_q] <= mul_p;
            mem_node[wr_q] <= tag_node_q[MUL_LAT-1];
            mem_last[wr_q] <= tag_last_q[MUL_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            num_q   <= '0;
            mula_q  <= '0;
            feat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                tag_node_q[i] <= '0;
                tag_last_q[i] <= 1'b0;
            end
        end else begin
            mula_q        <= mul_a;
            vld_q[0]      <= issue;
            tag_node_q[0] <= n_q;
            tag_last_q[0] <= is_last;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                vld_q[i]      <= vld_q[i-1];
                tag_node_q[i] <= tag_node_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end

            if (push) wr_q <= ptr_inc(wr_q);
            if (pop)  rd_q <= ptr_inc(rd_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_q  <= num_nodes;
                        feat_q <= feat_dim;
                        n_q    <= '0;
                        busy_q <= 1'b1;
                        if (num_nodes != '0) begin
                            state_q <= S_ISSUE;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        n_q <= n_q + NODE_W'(1);
                        if (is_last) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gat_row_base_addr_gen.sv
// Bench for gat_row_base_addr_gen: cycle-exact timing checks plus a randomized
// backpressure scoreboard against n*feat_dim computed arithmetically.
module tb_gat_row_base_addr_gen;
    logic        clk = 1'b0;
    logic        reset, start, addr_ready;
    logic [11:0] num_nodes;
    logic [7:0]  feat_dim;
    logic        busy, done, mul_ce, addr_valid, addr_last;
    logic [11:0] mul_a, addr_node;
    logic [7:0]  mul_b;
    logic [17:0] mul_p, addr;
    logic [17:0] p1, p2, p3;
    logic [19:0] full;

    int tests = 0;
    int fails = 0;

    gat_row_base_addr_gen #(
        .NODE_W(12), .DIM_W(8), .ADDR_W(18), .MUL_LAT(3), .DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_nodes(num_nodes),
        .feat_dim(feat_dim), .busy(busy), .done(done), .mul_ce(mul_ce),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .addr(addr), .addr_node(addr_node), .addr_last(addr_last)
    );

    always #5 clk = ~clk;

    // External 3-stage multiplier, truncating to 18 bits
    always_comb full = mul_a * mul_b;
    always_ff @(posedge clk) begin
        p1 <= full[17:0];
        p2 <= p1;
        p3 <= p2;
    end
    assign mul_p = p3;

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; addr_ready = 1'b1; num_nodes = '0; feat_dim = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, addr_valid, addr_last, mul_ce} !== 5'b00001 || mul_a !== 12'd0 || mul_b !== 8'd0) begin
            fails++;
            $display("FAIL reset: busy/done/valid/last/ce=%b%b%b%b%b mul_a=%0d mul_b=%0d, required 00001 0 0",
                     busy, done, addr_valid, addr_last, mul_ce, mul_a, mul_b);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Ready held high: every output is checked against its exact cycle offset from start.
    task automatic test_timed(input string name, input int n, input int fd, input int dup_k,
                              output int l_addr, output int l_node, output logic l_last);
        logic eb, ed, ev;
        int   node, ea;
        l_addr = -1; l_node = -1; l_last = 1'b0;
        addr_ready = 1'b1;
        start = 1'b1; num_nodes = 12'(n); feat_dim = 8'(fd);
        for (int k = 1; k <= n + 8; k++) begin
            @(negedge clk);
            start = (k == dup_k);
            if (k == dup_k) num_nodes = 12'(n + 3);
            if (n == 0) begin
                eb = (k == 1); ed = (k == 1); ev = 1'b0;
            end else begin
                eb = (k <= n + 5); ed = (k == n + 5); ev = (k >= 5) && (k <= n + 4);
            end
            tests++;
            if (busy !== eb || done !== ed || addr_valid !== ev) begin
                fails++;
                $display("FAIL %s ctrl k=%0d: busy/done/valid=%b%b%b, required %b%b%b",
                         name, k, busy, done, addr_valid, eb, ed, ev);
            end
            if (ev) begin
                node = k - 5;
                ea   = (node * fd) % 262144;
                tests++;
                if (addr !== 18'(ea) || addr_node !== 12'(node) || addr_last !== (node == n - 1)) begin
                    fails++;
                    $display("FAIL %s data k=%0d: addr=%0d node=%0d last=%b, required %0d %0d %b",
                             name, k, addr, addr_node, addr_last, ea, node, (node == n - 1));
                end
                l_addr = int'(addr); l_node = int'(addr_node); l_last = addr_last;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_basic();
        int a, nd; logic l;
        test_timed("basic", 4, 16, 0, a, nd, l);
        test_timed("empty", 0, 77, 0, a, nd, l);
        test_timed("start_busy", 6, 11, 3, a, nd, l);
        test_timed("timed_rand", $urandom_range(1, 30), $urandom_range(0, 255), 0, a, nd, l);
    endtask

    task automatic test_truncation();
        int a, nd; logic l;
        test_timed("trunc", 4095, 255, 0, a, nd, l);
        tests++;
        if (a !== 257538 || nd !== 4094 || l !== 1'b1) begin
            fails++;
            $display("FAIL trunc_last: addr=%0d node=%0d last=%b, required 257538 4094 1", a, nd, l);
        end
    endtask

    // Scoreboard pass; stall_cycles>=0 holds ready low that long, otherwise ready is random.
    task automatic run_scoreboard(input string name, input int n, input int fd, input int stall_cycles);
        int   idx, cyc;
        logic seen_done, stalled;
        logic [17:0] pa; logic [11:0] pn; logic pl;
        idx = 0; seen_done = 1'b0; stalled = 1'b0; pa = '0; pn = '0; pl = 1'b0;
        addr_ready = (stall_cycles < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        start = 1'b1; num_nodes = 12'(n); feat_dim = 8'(fd);
        for (cyc = 1; cyc < 600 && !seen_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (stalled) begin
                tests++;
                if (addr_valid !== 1'b1 || addr !== pa || addr_node !== pn || addr_last !== pl) begin
                    fails++;
                    $display("FAIL %s stable cyc=%0d: valid=%b addr=%0d node=%0d last=%b, required 1 %0d %0d %b",
                             name, cyc, addr_valid, addr, addr_node, addr_last, pa, pn, pl);
                end
            end
            if (stall_cycles >= 0 && cyc == stall_cycles - 1) begin
                tests++;
                if (mul_a !== 12'd7) begin
                    fails++;
                    $display("FAIL %s credit_stop: mul_a=%0d, required 7", name, mul_a);
                end
            end
            if (done) begin
                seen_done = 1'b1;
                tests++;
                if (idx != n || addr_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL %s count_at_done: entries=%0d valid=%b, required %0d 0", name, idx, addr_valid, n);
                end
            end
            addr_ready = (stall_cycles < 0) ? 1'($urandom_range(0, 1)) : (cyc >= stall_cycles);
            stalled = addr_valid && !addr_ready;
            pa = addr; pn = addr_node; pl = addr_last;
            if (addr_valid && addr_ready) begin
                tests++;
                if (idx >= n || addr !== 18'((idx * fd) % 262144) || addr_node !== 12'(idx) ||
                    addr_last !== (idx == n - 1)) begin
                    fails++;
                    $display("FAIL %s entry %0d: addr=%0d node=%0d last=%b, required %0d %0d %b",
                             name, idx, addr, addr_node, addr_last, (idx * fd) % 262144, idx, (idx == n - 1));
                end
                idx++;
            end
        end
        if (!seen_done) begin
            tests++; fails++;
            $display("FAIL %s timeout: done=0 after %0d cycles, required done pulse", name, cyc);
        end
        addr_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        run_scoreboard("backpressure", 20, 3, 30);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++)
            run_scoreboard("random", $urandom_range(1, 40), $urandom_range(0, 255), -1);
    endtask

    task automatic test_reset_mid_pass();
        int a, nd; logic l;
        addr_ready = 1'b1;
        start = 1'b1; num_nodes = 12'd10; feat_dim = 8'd7;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 7) reset = 1'b1;
        end
        tests++;
        if ({busy, done, addr_valid, addr_last} !== 4'b0000 || mul_a !== 12'd0 || mul_b !== 8'd0) begin
            fails++;
            $display("FAIL midreset: busy/done/valid/last=%b%b%b%b mul_a=%0d mul_b=%0d, required 0000 0 0",
                     busy, done, addr_valid, addr_last, mul_a, mul_b);
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || done !== 1'b0 || addr_valid !== 1'b0) begin
                fails++;
                $display("FAIL midreset_quiet k=%0d: busy/done/valid=%b%b%b, required 000", k, busy, done, addr_valid);
            end
        end
        test_timed("after_reset", 2, 5, 0, a, nd, l);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_reset_mid_pass();
        test_truncation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
